// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: picks a target box, debounces the sensor code,
// judges hit / wrong box / timeout and keeps score, miss and round counts.
module mole_round_controller #(
  parameter int unsigned N_BOXES         = 4,
  parameter int unsigned SHOW_CYCLES     = 50000000,
  parameter int unsigned GAP_CYCLES      = 12500000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_ROUNDS      = 16,
  parameter int unsigned MAX_MISSES      = 3,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] sensor_code,
  output logic [2:0] target_box,
  output logic       target_valid,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] score,
  output logic [1:0] misses,
  output logic [4:0] round_num,
  output logic       game_over,
  output logic       busy
);

  localparam int unsigned BOX_W = 3;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       N_BOXES_B = 8'(N_BOXES);
  localparam logic [BOX_W-1:0] LAST_BOX  = BOX_W'(N_BOXES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_SHOW,
    S_HIT,
    S_MISS,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         lfsr;
  logic [BOX_W-1:0]   prev_target;
  logic [CNT_W-1:0]   timer;
  logic [BOX_W-1:0]   sync1;
  logic [BOX_W-1:0]   sync2;
  logic [BOX_W-1:0]   deb_code;
  logic [CNT_W-1:0]   deb_cnt;
  logic [BOX_W-1:0]   cand;
  logic [BOX_W-1:0]   cand_next;
  logic [BOX_W-1:0]   pick_box;
  logic               game_end;

  // Sensor path: two-flop synchroniser, then accept a code held stable long enough
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1    <= '0;
      sync2    <= '0;
      deb_cnt  <= '0;
      deb_code <= '0;
    end else begin
      sync1 <= sensor_code;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_code <= sync2;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  // Target choice: never repeat the previous box
  always_comb begin
    cand      = BOX_W'(lfsr % N_BOXES_B) + BOX_W'(1);
    cand_next = (cand == LAST_BOX) ? BOX_W'(1) : cand + BOX_W'(1);
    pick_box  = (cand == prev_target) ? cand_next : cand;
  end

  assign game_end = (round_num == 5'(NUM_ROUNDS)) || (misses == 2'(MAX_MISSES));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_PICK;
      end
      S_PICK: state_nxt = S_SHOW;
      S_SHOW: begin
        if (deb_code == target_box) begin
          state_nxt = S_HIT;
        end else if (deb_code != BOX_W'(0)) begin
          state_nxt = S_MISS;
        end else if (timer == SHOW_LAST) begin
          state_nxt = S_MISS;
        end
      end
      S_HIT, S_MISS: state_nxt = S_GAP;
      S_GAP: begin
        // The next round waits for the player to let go of the box
        if ((timer >= GAP_LAST) && (deb_code == BOX_W'(0))) begin
          state_nxt = game_end ? S_DONE : S_PICK;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, LFSR and registered outputs; status flags follow the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      lfsr         <= 8'hA5;
      prev_target  <= '0;
      timer        <= '0;
      target_box   <= '0;
      target_valid <= 1'b0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      score        <= '0;
      misses       <= '0;
      round_num    <= '0;
      game_over    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      target_valid <= (state_nxt == S_SHOW);
      hit_pulse    <= (state_nxt == S_HIT);
      miss_pulse   <= (state_nxt == S_MISS);
      game_over    <= (state_nxt == S_DONE);
      busy         <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score     <= '0;
            misses    <= '0;
            round_num <= '0;
          end
        end
        S_PICK: begin
          target_box  <= pick_box;
          prev_target <= pick_box;
          timer       <= '0;
        end
        S_SHOW: timer <= timer + CNT_W'(1);
        S_HIT: begin
          if (score != 8'hFF) score <= score + 8'd1;
          if (round_num != 5'd31) round_num <= round_num + 5'd1;
          target_box <= '0;
          timer      <= '0;
        end
        S_MISS: begin
          if (misses != 2'd3) misses <= misses + 2'd1;
          if (round_num != 5'd31) round_num <= round_num + 5'd1;
          target_box <= '0;
          timer      <= '0;
        end
        S_GAP: begin
          if (timer < GAP_LAST) timer <= timer + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_controller.sv
// Randomised bench for mole_round_controller against a round-level score model.
module tb_mole_round_controller;

  localparam int unsigned N_BOXES         = 4;
  localparam int unsigned SHOW_CYCLES     = 20;
  localparam int unsigned GAP_CYCLES      = 5;
  localparam int unsigned DEBOUNCE_CYCLES = 3;
  localparam int unsigned NUM_ROUNDS      = 4;
  localparam int unsigned MAX_MISSES      = 2;
  localparam int unsigned CNT_W           = 8;

  localparam int K_HIT     = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_WRONG   = 2;
  localparam int K_BOUNCE  = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [2:0] sensor_code = 3'd0;
  logic [2:0] target_box;
  logic       target_valid;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] score;
  logic [1:0] misses;
  logic [4:0] round_num;
  logic       game_over;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game counters and the last target shown
  logic [7:0] m_score;
  logic [1:0] m_misses;
  logic [4:0] m_round;
  logic [2:0] m_prev;

  always #5 clk = ~clk;

  mole_round_controller #(
    .N_BOXES(N_BOXES), .SHOW_CYCLES(SHOW_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NUM_ROUNDS(NUM_ROUNDS),
    .MAX_MISSES(MAX_MISSES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .sensor_code(sensor_code),
    .target_box(target_box), .target_valid(target_valid), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .score(score), .misses(misses), .round_num(round_num),
    .game_over(game_over), .busy(busy)
  );

  // Pulses never overlap and never coincide with a lit target window
  always @(posedge clk) begin
    #2;
    if (resetn && (hit_pulse || miss_pulse)) begin
      n_checks++;
      if ((hit_pulse && miss_pulse) || target_valid) begin
        n_fail++;
        $display("FAIL pulse_exclusive: hit=%0b miss=%0b target_valid=%0b, required single pulse with target_valid=0",
                 hit_pulse, miss_pulse, target_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_over();
    return (m_round == 5'(NUM_ROUNDS)) || (m_misses == 2'(MAX_MISSES));
  endfunction

  task automatic apply_reset();
    resetn = 1'b0;
    start = 1'b0;
    sensor_code = 3'd0;
    #1;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    m_score = '0; m_misses = '0; m_round = '0; m_prev = '0;
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = '0; m_misses = '0; m_round = '0;
  endtask

  task automatic wait_game_over(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 60 && !ok; w++) begin
      if (game_over === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  // Plays one round with the given player behaviour and checks it against the model
  task automatic play_round(input int kind, input bit poke_start);
    bit         seen;
    bit         exp_hit;
    int         hits;
    int         missp;
    int         pulse_at;
    int         exp_at;
    logic [2:0] tgt;
    logic [2:0] wrong;
    seen = 1'b0;
    for (int w = 0; w < 80 && !seen; w++) begin
      if (target_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL round_start: target_valid=%0b after 80 clocks, required 1", target_valid);
      return;
    end
    tgt = target_box;
    n_checks++;
    if (tgt < 3'd1 || tgt > 3'(N_BOXES) || tgt == m_prev) begin
      n_fail++;
      $display("FAIL target_pick: target_box=%0d prev=%0d, required 1..%0d and different from prev",
               tgt, m_prev, N_BOXES);
    end
    m_prev = tgt;
    wrong = tgt ^ 3'd1;
    if (wrong == 3'd0) wrong = 3'd2;
    exp_hit = (kind == K_HIT);
    exp_at = (kind == K_HIT || kind == K_WRONG) ? int'(DEBOUNCE_CYCLES) + 3 : int'(SHOW_CYCLES);
    hits = 0; missp = 0; pulse_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (hit_pulse === 1'b1) hits++;
      if (miss_pulse === 1'b1) missp++;
      if ((hit_pulse === 1'b1 || miss_pulse === 1'b1) && pulse_at < 0) begin
        pulse_at = i;
        if (m_round != 5'd31) m_round = m_round + 5'd1;
        if (exp_hit) begin
          if (m_score != 8'hFF) m_score = m_score + 8'd1;
        end else begin
          if (m_misses != 2'd3) m_misses = m_misses + 2'd1;
        end
      end
      if (pulse_at >= 0 && i == pulse_at + 1) begin
        n_checks++;
        if ({score, misses, round_num} !== {m_score, m_misses, m_round} ||
            {target_valid, target_box, busy, game_over} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL gap_entry: score=%0d misses=%0d round=%0d tv=%0b box=%0d busy=%0b over=%0b, required %0d/%0d/%0d tv=0 box=0 busy=1 over=0",
                   score, misses, round_num, target_valid, target_box, busy, game_over,
                   m_score, m_misses, m_round);
        end
      end
      if (pulse_at >= 0 && i > pulse_at + 1 && i >= 10) break;
      case (kind)
        K_HIT:    sensor_code = (i < 10) ? tgt : 3'd0;
        K_WRONG:  sensor_code = (i < 10) ? wrong : 3'd0;
        K_BOUNCE: sensor_code = (i < 20 && ((i / 2) % 2 == 0)) ? tgt : 3'd0;
        default:  sensor_code = 3'd0;
      endcase
      start = poke_start && (i == 2);
      tick();
    end
    sensor_code = 3'd0;
    start = 1'b0;
    n_checks++;
    if (hits != (exp_hit ? 1 : 0) || missp != (exp_hit ? 0 : 1)) begin
      n_fail++;
      $display("FAIL round_pulses(kind %0d): hit_pulses=%0d miss_pulses=%0d, required %0d/%0d",
               kind, hits, missp, exp_hit ? 1 : 0, exp_hit ? 0 : 1);
    end
    n_checks++;
    if (pulse_at != exp_at) begin
      n_fail++;
      $display("FAIL round_latency(kind %0d): pulse on clock %0d after target_valid rise (rise clock = 1), required %0d",
               kind, pulse_at + 1, exp_at + 1);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({target_box, target_valid, hit_pulse, miss_pulse, score, misses, round_num, game_over, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_values: outputs=%h, required 0",
               {target_box, target_valid, hit_pulse, miss_pulse, score, misses, round_num, game_over, busy});
    end
    repeat (2) tick();
    resetn = 1'b1;
    m_score = '0; m_misses = '0; m_round = '0; m_prev = '0;
    repeat (50) tick();
    n_checks++;
    if ({target_box, target_valid, hit_pulse, miss_pulse, score, misses, round_num, game_over, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL idle_hold: outputs=%h after 50 idle clocks, required 0",
               {target_box, target_valid, hit_pulse, miss_pulse, score, misses, round_num, game_over, busy});
    end
  endtask

  task automatic test_hit();
    apply_reset();
    start_game();
    play_round(K_HIT, 1'b0);
    play_round(K_HIT, 1'b0);
  endtask

  task automatic test_timeout();
    apply_reset();
    start_game();
    play_round(K_TIMEOUT, 1'b0);
  endtask

  task automatic test_bounce_wrong();
    bit ok;
    apply_reset();
    start_game();
    play_round(K_BOUNCE, 1'b0);
    play_round(K_WRONG, 1'b0);
    wait_game_over(ok);
    n_checks++;
    if (!ok || score !== 8'd0 || misses !== 2'd2) begin
      n_fail++;
      $display("FAIL bounce_wrong_end: over=%0b score=%0d misses=%0d, required 1/0/2", game_over, score, misses);
    end
  endtask

  task automatic test_game_end();
    bit ok;
    apply_reset();
    start_game();
    play_round(K_TIMEOUT, 1'b0);
    play_round(K_TIMEOUT, 1'b0);
    wait_game_over(ok);
    n_checks++;
    if (!ok || round_num !== 5'd2 || busy !== 1'b0 || misses !== 2'd2) begin
      n_fail++;
      $display("FAIL miss_limit_end: over=%0b round=%0d busy=%0b misses=%0d, required 1/2/0/2",
               game_over, round_num, busy, misses);
    end
    start_game();
    n_checks++;
    if ({score, misses, round_num, game_over, busy} !== {8'd0, 2'd0, 5'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_clear: score=%0d misses=%0d round=%0d over=%0b busy=%0b, required 0/0/0/0/1",
               score, misses, round_num, game_over, busy);
    end
    for (int r = 0; r < int'(NUM_ROUNDS); r++) play_round(K_HIT, 1'b0);
    wait_game_over(ok);
    n_checks++;
    if (!ok || score !== 8'd4 || round_num !== 5'(NUM_ROUNDS) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL round_limit_end: over=%0b score=%0d round=%0d busy=%0b, required 1/4/%0d/0",
               game_over, score, round_num, busy, NUM_ROUNDS);
    end
    start_game();
    n_checks++;
    if (score !== 8'd0 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_from_done: score=%0d over=%0b, required 0/0", score, game_over);
    end
    play_round(K_HIT, 1'b0);
  endtask

  task automatic test_release_gating();
    bit         seen;
    bit         lit_in_gap;
    int         hits;
    int         rise;
    logic [2:0] tgt;
    apply_reset();
    start_game();
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      if (target_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    tgt = target_box;
    m_prev = tgt;
    sensor_code = tgt;
    hits = 0; lit_in_gap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hit_pulse === 1'b1) hits++;
      if (hits > 0 && hit_pulse !== 1'b1 && target_valid !== 1'b0) lit_in_gap = 1'b1;
    end
    n_checks++;
    if (!seen || hits != 1 || lit_in_gap || busy !== 1'b1 || score !== 8'd1 || round_num !== 5'd1) begin
      n_fail++;
      $display("FAIL held_sensor_gap: hits=%0d relit=%0b busy=%0b score=%0d round=%0d, required 1/0/1/1/1",
               hits, lit_in_gap, busy, score, round_num);
    end
    sensor_code = 3'd0;
    rise = -1;
    for (int k = 1; k <= 30 && rise < 0; k++) begin
      tick();
      if (target_valid === 1'b1) rise = k;
    end
    n_checks++;
    if (rise != int'(DEBOUNCE_CYCLES) + 4) begin
      n_fail++;
      $display("FAIL release_to_next_round: target_valid rose %0d clocks after release, required %0d",
               rise, DEBOUNCE_CYCLES + 4);
    end
  endtask

  task automatic test_reset_mid_show();
    bit seen;
    bit pulsed;
    apply_reset();
    start_game();
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      if (target_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    repeat (3) tick();
    resetn = 1'b0;
    #1;
    n_checks++;
    if (!seen || {target_box, target_valid, hit_pulse, miss_pulse, score, misses, round_num, game_over, busy} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_mid_show: seen_show=%0b outputs=%h, required 1 and 0", seen,
               {target_box, target_valid, hit_pulse, miss_pulse, score, misses, round_num, game_over, busy});
    end
    repeat (2) tick();
    resetn = 1'b1;
    m_score = '0; m_misses = '0; m_round = '0; m_prev = '0;
    pulsed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0 || busy !== 1'b0) pulsed = 1'b1;
    end
    n_checks++;
    if (pulsed) begin
      n_fail++;
      $display("FAIL after_reset_quiet: saw pulse or busy after reset release, required none");
    end
  endtask

  task automatic test_random_games();
    bit ok;
    apply_reset();
    for (int g = 0; g < 6; g++) begin
      start_game();
      while (!model_over()) begin
        play_round(int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
      end
      wait_game_over(ok);
      n_checks++;
      if (!ok || busy !== 1'b0 || {score, misses, round_num} !== {m_score, m_misses, m_round}) begin
        n_fail++;
        $display("FAIL random_game_end(%0d): over=%0b busy=%0b score=%0d misses=%0d round=%0d, required 1/0/%0d/%0d/%0d",
                 g, game_over, busy, score, misses, round_num, m_score, m_misses, m_round);
      end
      repeat (int'($urandom_range(5, 0))) tick();
    end
  endtask

  initial begin
    m_score = '0; m_misses = '0; m_round = '0; m_prev = '0;
    #2;
    test_reset();
    test_hit();
    test_timeout();
    test_bounce_wrong();
    test_game_end();
    test_release_gating();
    test_reset_mid_show();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
